b_colvec_loader: RTL



---
 rtl/b_colvec_pkg.sv | 12 +
 rtl/b_colvec_loader_stagger.sv | 31 +++
 rtl/b_colvec_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/b_colvec_pkg.sv
// Shared widths, element type and state encodings for the B column-vector loader.
package b_colvec_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned SEL_W  = 5;

    typedef logic signed [DATA_W-1:0] b_elem_t;

    typedef enum logic { F_FILL, F_HOLD } fill_state_e;
    typedef enum logic { S_IDLE, S_RUN  } sweep_state_e;

endpackage

// File: rtl/b_colvec_loader_stagger.sv
// b_sel_stagger: CASCADE_LEN-stage shift line carrying {mux_vld, muxsel}, one stage per DSP.
module b_sel_stagger
    import b_colvec_pkg::*;
#(
    parameter int unsigned CASCADE_LEN = 32
) (
    input  logic                                clk,
    input  logic                                clr,
    input  logic                                vld_i,
    input  logic [SEL_W-1:0]                    sel_i,
    output logic [CASCADE_LEN-1:0]              vld_o,
    output logic [CASCADE_LEN-1:0][SEL_W-1:0]   sel_o
);

    logic [CASCADE_LEN-1:0]            vld_q;
    logic [CASCADE_LEN-1:0][SEL_W-1:0] sel_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
            sel_q <= '0;
        end else begin
            vld_q <= {vld_q[CASCADE_LEN-2:0], vld_i};
            sel_q <= {sel_q[CASCADE_LEN-2:0], sel_i};
        end
    end

    assign vld_o = vld_q;
    assign sel_o = sel_q;

endmodule

// File: rtl/b_colvec_loader.sv
// B-operand column bank loader and staggered column-select sweep generator.
// Define B_COLVEC_PINGPONG_EN for two ping-pong banks; default build uses a single bank.
module b_colvec_loader
    import b_colvec_pkg::*;
#(
    parameter int unsigned N           = 32,
    parameter int unsigned CASCADE_LEN = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic signed [DATA_W-1:0]                      s_tdata,
    input  logic                                          s_tvalid,
    output logic                                          s_tready,
    input  logic                                          s_tlast,
    input  logic                                          start,
    output logic [N-1:0][CASCADE_LEN-1:0][DATA_W-1:0]     colvec_ff_vec,
    output logic [CASCADE_LEN-1:0][SEL_W-1:0]             muxsel,
    output logic [CASCADE_LEN-1:0]                        mux_vld,
    output logic                                          bank_valid,
    output logic                                          sweep_busy,
    output logic                                          sweep_done,
    output logic                                          frame_err
);

    localparam int unsigned COL_W = $clog2(N);
    localparam int unsigned ROW_W = $clog2(CASCADE_LEN);
    localparam int unsigned CNT_W = $clog2(N + CASCADE_LEN - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(N - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(CASCADE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N + CASCADE_LEN - 2);
    localparam logic [CNT_W-1:0] CNT_ISSUE = CNT_W'(N - 1);
`ifdef B_COLVEC_PINGPONG_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif

    fill_state_e  fill_q, fill_d;
    sweep_state_e sweep_q, sweep_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic bank_valid_q, bank_valid_d;
    logic frame_err_q, frame_err_d;
    logic sweep_done_q, sweep_done_d;
    logic wr_en, wr_idx, rd_idx, last_word, sweep_end;
    logic stg_vld;
    logic [SEL_W-1:0] stg_sel;

    b_elem_t [NBANK-1:0][N-1:0][CASCADE_LEN-1:0] bank_q;

`ifdef B_COLVEC_PINGPONG_EN
    logic act_q, act_d;
    assign wr_idx = ~act_q;
    assign rd_idx = act_q;
`else
    assign wr_idx = 1'b0;
    assign rd_idx = 1'b0;
`endif

    assign last_word = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign sweep_end = (sweep_q == S_RUN) && (cnt_q == CNT_LAST);

    always_comb begin
        fill_d       = fill_q;
        col_d        = col_q;
        row_d        = row_q;
        bank_valid_d = bank_valid_q;
        frame_err_d  = frame_err_q;
        wr_en        = 1'b0;
`ifdef B_COLVEC_PINGPONG_EN
        act_d        = act_q;
`endif
        if (sweep_end) bank_valid_d = 1'b0;
        case (fill_q)
            F_FILL: begin
                if (s_tvalid) begin
                    wr_en = 1'b1;
                    if (last_word) begin
                        col_d = '0;
                        row_d = '0;
                        if (!s_tlast) frame_err_d = 1'b1;
`ifdef B_COLVEC_PINGPONG_EN
                        if (!bank_valid_q && sweep_q == S_IDLE) begin
                            act_d        = ~act_q;
                            bank_valid_d = 1'b1;
                        end else begin
                            fill_d = F_HOLD;
                        end
`else
                        bank_valid_d = 1'b1;
                        fill_d       = F_HOLD;
`endif
                    end else if (s_tlast) begin
                        frame_err_d = 1'b1;
                        col_d       = '0;
                        row_d       = '0;
                    end else if (row_q == ROW_LAST) begin
                        row_d = '0;
                        col_d = col_q + 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            F_HOLD: begin
`ifdef B_COLVEC_PINGPONG_EN
                // Active bank is empty only on the sweep_done cycle once a frame is held.
                if (!bank_valid_q && sweep_q == S_IDLE) begin
                    act_d        = ~act_q;
                    bank_valid_d = 1'b1;
                    fill_d       = F_FILL;
                end
`else
                if (sweep_done_q) fill_d = F_FILL;
`endif
            end
            default: fill_d = F_FILL;
        endcase
    end

    // Stage-0 value is computed one cycle early so muxsel[0] is registered yet lands at start+1.
    always_comb begin
        sweep_d      = sweep_q;
        cnt_d        = cnt_q;
        sweep_done_d = 1'b0;
        stg_vld      = 1'b0;
        stg_sel      = '0;
        case (sweep_q)
            S_IDLE: begin
                if (start && bank_valid_q && !sweep_done_q) begin
                    sweep_d = S_RUN;
                    cnt_d   = '0;
                    stg_vld = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    sweep_d      = S_IDLE;
                    sweep_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_q < CNT_ISSUE) begin
                    stg_vld = 1'b1;
                    stg_sel = SEL_W'(cnt_q + 1'b1);
                end
            end
            default: sweep_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q       <= F_FILL;
            sweep_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            cnt_q        <= '0;
            bank_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            sweep_done_q <= 1'b0;
`ifdef B_COLVEC_PINGPONG_EN
            act_q        <= 1'b0;
`endif
        end else begin
            fill_q       <= fill_d;
            sweep_q      <= sweep_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            bank_valid_q <= bank_valid_d;
            frame_err_q  <= frame_err_d;
            sweep_done_q <= sweep_done_d;
`ifdef B_COLVEC_PINGPONG_EN
            act_q        <= act_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) bank_q[wr_idx][col_q][row_q] <= s_tdata;
    end

    b_sel_stagger #(
        .CASCADE_LEN(CASCADE_LEN)
    ) u_stagger (
        .clk  (clk),
        .clr  (reset),
        .vld_i(stg_vld),
        .sel_i(stg_sel),
        .vld_o(mux_vld),
        .sel_o(muxsel)
    );

    assign colvec_ff_vec = bank_q[rd_idx];
    assign s_tready      = (fill_q == F_FILL);
    assign bank_valid    = bank_valid_q;
    assign sweep_busy    = (sweep_q == S_RUN);
    assign sweep_done    = sweep_done_q;
    assign frame_err     = frame_err_q;

endmodule
